seq_divider: RTL and testbench

Parametrised multi-cycle integer divider with valid/ready handshakes on input and output, producing quotient and remainder. It computes one restoring shift-subtract step per cycle and captures its operands at acceptance. It supports unsigned or signed (truncating) division and flags divide-by-zero. It sits between the sample-processing datapath and any consumer needing ratios, and replaces ad-hoc search dividers that read live inputs.

---
 rtl/seq_divider_pkg.sv | 15 +
 rtl/seq_divider_if.sv | 26 ++
 rtl/seq_divider_step.sv | 20 ++
 rtl/seq_divider.sv | 107 ++++++++++
 tb/tb_seq_divider.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_DONE
  } div_state_t;

  // The iteration counter must also hold the value WIDTH, which marks the fix-up cycle.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
interface seq_divider_if #(
  parameter int WIDTH = 16
);
  // A transfer happens on a rising edge where valid and ready are both high.
  // Once valid is high, it and its data stay stable until that transfer.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_step.sv
// One restoring shift-subtract iteration, purely combinational.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {2'b00, divisor};
    q_bit   = ~diff[WIDTH+1];
    rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle integer divider: captures operands, runs WIDTH restoring steps,
// then applies sign fix-up and holds the result until the consumer takes it.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  seq_divider_if.slave bus,
  output div_state_t   state
);
  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dsr_r;
  logic             neg_q;
  logic             neg_r;
  logic             zero_r;

  logic [WIDTH:0]   step_rem;
  logic             step_bit;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .divisor (dsr_r),
    .bit_in  (quo_r[WIDTH-1]),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  always_comb begin
    a_neg = SIGNED && bus.dividend[WIDTH-1];
    b_neg = SIGNED && bus.divisor[WIDTH-1];
    a_abs = a_neg ? -bus.dividend : bus.dividend;
    b_abs = b_neg ? -bus.divisor  : bus.divisor;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= DIV_IDLE;
      cnt             <= '0;
      rem_r           <= '0;
      quo_r           <= '0;
      dsr_r           <= '0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      zero_r          <= 1'b0;
      bus.in_ready    <= 1'b1;
      bus.out_valid   <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (bus.in_valid) begin
            // A zero divisor keeps the raw dividend and skips straight to the fix-up cycle.
            zero_r          <= (bus.divisor == '0);
            neg_q           <= a_neg ^ b_neg;
            neg_r           <= a_neg;
            dsr_r           <= b_abs;
            rem_r           <= '0;
            quo_r           <= (bus.divisor == '0) ? bus.dividend : a_abs;
            cnt             <= (bus.divisor == '0) ? CW'(WIDTH) : '0;
            bus.div_by_zero <= 1'b0;
            bus.in_ready    <= 1'b0;
            state           <= DIV_CALC;
          end
        end
        DIV_CALC: begin
          if (cnt == CW'(WIDTH)) begin
            if (zero_r) begin
              bus.quotient    <= '1;
              bus.remainder   <= quo_r;
              bus.div_by_zero <= 1'b1;
            end else begin
              bus.quotient    <= neg_q ? -quo_r : quo_r;
              bus.remainder   <= neg_r ? -rem_r[WIDTH-1:0] : rem_r[WIDTH-1:0];
            end
            bus.out_valid <= 1'b1;
            state         <= DIV_DONE;
          end else begin
            rem_r <= step_rem;
            quo_r <= {quo_r[WIDTH-2:0], step_bit};
            cnt   <= cnt + 1'b1;
          end
        end
        DIV_DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= DIV_IDLE;
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: four instances (16/8 bit, unsigned/signed) behind one shared driver.
module tb_seq_divider;
  import div_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int          sel = 0;
  logic        drv_valid = 1'b0;
  logic        drv_rdy = 1'b0;
  logic [15:0] drv_a = '0;
  logic [15:0] drv_b = '0;

  int total = 0;
  int bad = 0;
  logic [32:0] exp_q[$];

  seq_divider_if #(.WIDTH(16)) if_u16 ();
  seq_divider_if #(.WIDTH(16)) if_s16 ();
  seq_divider_if #(.WIDTH(8))  if_u8 ();
  seq_divider_if #(.WIDTH(8))  if_s8 ();
  div_state_t st_u16, st_s16, st_u8, st_s8;

  seq_divider #(.WIDTH(16), .SIGNED(1'b0)) dut_u16 (.clk(clk), .reset(reset), .bus(if_u16), .state(st_u16));
  seq_divider #(.WIDTH(16), .SIGNED(1'b1)) dut_s16 (.clk(clk), .reset(reset), .bus(if_s16), .state(st_s16));
  seq_divider #(.WIDTH(8),  .SIGNED(1'b0)) dut_u8  (.clk(clk), .reset(reset), .bus(if_u8),  .state(st_u8));
  seq_divider #(.WIDTH(8),  .SIGNED(1'b1)) dut_s8  (.clk(clk), .reset(reset), .bus(if_s8),  .state(st_s8));

  assign if_u16.in_valid  = drv_valid && (sel == 0);
  assign if_u16.out_ready = drv_rdy && (sel == 0);
  assign if_u16.dividend  = drv_a;
  assign if_u16.divisor   = drv_b;
  assign if_s16.in_valid  = drv_valid && (sel == 1);
  assign if_s16.out_ready = drv_rdy && (sel == 1);
  assign if_s16.dividend  = drv_a;
  assign if_s16.divisor   = drv_b;
  assign if_u8.in_valid   = drv_valid && (sel == 2);
  assign if_u8.out_ready  = drv_rdy && (sel == 2);
  assign if_u8.dividend   = drv_a[7:0];
  assign if_u8.divisor    = drv_b[7:0];
  assign if_s8.in_valid   = drv_valid && (sel == 3);
  assign if_s8.out_ready  = drv_rdy && (sel == 3);
  assign if_s8.dividend   = drv_a[7:0];
  assign if_s8.divisor    = drv_b[7:0];

  logic        m_in_ready, m_out_valid, m_dbz;
  logic [15:0] m_q, m_r;
  div_state_t  m_state;

  always_comb begin
    m_in_ready = if_u16.in_ready; m_out_valid = if_u16.out_valid; m_dbz = if_u16.div_by_zero;
    m_q = if_u16.quotient; m_r = if_u16.remainder; m_state = st_u16;
    case (sel)
      1: begin
        m_in_ready = if_s16.in_ready; m_out_valid = if_s16.out_valid; m_dbz = if_s16.div_by_zero;
        m_q = if_s16.quotient; m_r = if_s16.remainder; m_state = st_s16;
      end
      2: begin
        m_in_ready = if_u8.in_ready; m_out_valid = if_u8.out_valid; m_dbz = if_u8.div_by_zero;
        m_q = {8'h00, if_u8.quotient}; m_r = {8'h00, if_u8.remainder}; m_state = st_u8;
      end
      3: begin
        m_in_ready = if_s8.in_ready; m_out_valid = if_s8.out_valid; m_dbz = if_s8.div_by_zero;
        m_q = {8'h00, if_s8.quotient}; m_r = {8'h00, if_s8.remainder}; m_state = st_s8;
      end
      default: ;
    endcase
  end

  // Reference: native integer division truncates toward zero, % takes the dividend's sign.
  function automatic logic [32:0] ref_div(input int w, input bit sgn, input logic [15:0] a, input logic [15:0] b);
    int mask, ua, ub, sa, sb, q, r;
    logic [15:0] qq, rr;
    logic z;
    mask = (1 << w) - 1;
    ua = int'(a) & mask;
    ub = int'(b) & mask;
    z = (ub == 0);
    if (z) begin
      q = mask;
      r = ua;
    end else if (sgn) begin
      sa = ((ua >> (w - 1)) & 1) != 0 ? ua - (1 << w) : ua;
      sb = ((ub >> (w - 1)) & 1) != 0 ? ub - (1 << w) : ub;
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    qq = 16'(q & mask);
    rr = 16'(r & mask);
    return {z, qq, rr};
  endfunction

  task automatic drive_op(input int s, input logic [15:0] a, input logic [15:0] b, input logic [32:0] e,
                          input bit rel, output int lat, output logic [32:0] obs);
    int n;
    sel = s;
    drv_rdy = 1'b0;
    n = 0;
    while (!m_in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    drv_a = a;
    drv_b = b;
    drv_valid = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(e);
    drv_valid = 1'b0;
    drv_a = 16'($urandom);
    drv_b = 16'($urandom);
    lat = 0;
    while (!m_out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!m_out_valid) lat = -1;
    obs = {m_dbz, m_q, m_r};
    if (rel) begin
      drv_rdy = 1'b1;
      @(posedge clk); #1;
      drv_rdy = 1'b0;
    end
  endtask

  task automatic test_reset();
    sel = 0;
    total++;
    if ({m_in_ready, m_out_valid, m_dbz, m_q, m_r} !== {1'b1, 1'b0, 1'b0, 16'h0, 16'h0}) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b dbz=%b q=%h r=%h want 1 0 0 0000 0000",
               m_in_ready, m_out_valid, m_dbz, m_q, m_r);
    end
    total++;
    if (m_state !== DIV_IDLE) begin
      bad++;
      $display("FAIL reset_state: got %0d want %0d", m_state, DIV_IDLE);
    end
  endtask

  task automatic test_unsigned();
    int lat;
    logic [32:0] obs, e;
    drive_op(0, 16'd100, 16'd7, {1'b0, 16'd14, 16'd2}, 1'b1, lat, obs);
    e = exp_q.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("FAIL u100_7: got %h want %h", obs, e); end
    total++;
    if (lat != 17) begin bad++; $display("FAIL u100_7_latency: got %0d want 17", lat); end
  endtask

  task automatic test_div_zero();
    int lat;
    logic [32:0] obs, e;
    drive_op(0, 16'd1234, 16'd0, {1'b1, 16'hFFFF, 16'd1234}, 1'b1, lat, obs);
    e = exp_q.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("FAIL div0: got %h want %h", obs, e); end
    total++;
    if (lat != 1) begin bad++; $display("FAIL div0_latency: got %0d want 1", lat); end
    drive_op(0, 16'd9, 16'd3, {1'b0, 16'd3, 16'd0}, 1'b1, lat, obs);
    e = exp_q.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("FAIL after_div0: got %h want %h", obs, e); end
  endtask

  task automatic test_signed();
    int lat;
    logic [32:0] obs, e;
    logic [15:0] ta[3] = '{16'hFFF9, 16'h0007, 16'h8000};
    logic [15:0] tb[3] = '{16'h0002, 16'hFFFE, 16'hFFFF};
    logic [32:0] te[3] = '{{1'b0, 16'hFFFD, 16'hFFFF}, {1'b0, 16'hFFFD, 16'h0001}, {1'b0, 16'h8000, 16'h0000}};
    for (int i = 0; i < 3; i++) begin
      drive_op(1, ta[i], tb[i], te[i], 1'b1, lat, obs);
      e = exp_q.pop_front();
      total++;
      if (obs !== e || lat != 17) begin
        bad++;
        $display("FAIL signed_%0d: got %h lat=%0d want %h lat=17", i, obs, lat, e);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [32:0] obs, e;
    drive_op(0, 16'd5000, 16'd33, {1'b0, 16'd151, 16'd17}, 1'b0, lat, obs);
    for (int i = 0; i < 10; i++) begin
      drv_valid = 1'($urandom_range(0, 1));
      drv_a = 16'($urandom);
      drv_b = 16'($urandom);
      @(posedge clk); #1;
      total++;
      if ({m_dbz, m_q, m_r} !== obs || m_in_ready !== 1'b0 || m_out_valid !== 1'b1) begin
        bad++;
        $display("FAIL hold_%0d: got %h rdy=%b vld=%b want %h rdy=0 vld=1",
                 i, {m_dbz, m_q, m_r}, m_in_ready, m_out_valid, obs);
      end
    end
    drv_valid = 1'b0;
    drv_rdy = 1'b1;
    @(posedge clk); #1;
    drv_rdy = 1'b0;
    total++;
    if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0 || m_state !== DIV_IDLE) begin
      bad++;
      $display("FAIL release: got rdy=%b vld=%b st=%0d want 1 0 IDLE", m_in_ready, m_out_valid, m_state);
    end
    e = exp_q.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("FAIL hold_result: got %h want %h", obs, e); end
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    logic [32:0] obs, e;
    sel = 0;
    drv_a = 16'd777;
    drv_b = 16'd3;
    drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if ({m_in_ready, m_out_valid, m_q, m_r} !== {1'b1, 1'b0, 16'h0, 16'h0} || m_state !== DIV_IDLE) begin
      bad++;
      $display("FAIL reset_mid_calc: got rdy=%b vld=%b q=%h r=%h st=%0d want 1 0 0000 0000 IDLE",
               m_in_ready, m_out_valid, m_q, m_r, m_state);
    end
    drive_op(0, 16'd50, 16'd5, {1'b0, 16'd10, 16'd0}, 1'b1, lat, obs);
    e = exp_q.pop_front();
    total++;
    if (obs !== e || lat != 17) begin
      bad++;
      $display("FAIL after_reset: got %h lat=%0d want %h lat=17", obs, lat, e);
    end
  endtask

  task automatic test_sweep8(input int s, input bit sgn, input int n);
    int lat, want_lat;
    logic [32:0] obs, e;
    logic [15:0] a, b;
    logic [7:0] ca[8] = '{8'h80, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h05};
    logic [7:0] cb[8] = '{8'hFF, 8'h01, 8'h80, 8'h03, 8'hFF, 8'h00, 8'h80, 8'hFB};
    for (int i = 0; i < n; i++) begin
      if (i < 8) begin
        a = {8'h00, ca[i]};
        b = {8'h00, cb[i]};
      end else begin
        a = 16'($urandom_range(0, 255));
        b = (i % 16 == 0) ? 16'h0 : 16'($urandom_range(0, 255));
      end
      drive_op(s, a, b, ref_div(8, sgn, a, b), 1'b1, lat, obs);
      want_lat = (b[7:0] == 8'h0) ? 1 : 9;
      e = exp_q.pop_front();
      total++;
      if (obs !== e || lat != want_lat) begin
        bad++;
        $display("FAIL sweep_s%0d %h/%h: got %h lat=%0d want %h lat=%0d", s, a[7:0], b[7:0], obs, lat, e, want_lat);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_unsigned();
    test_div_zero();
    test_signed();
    test_backpressure();
    test_reset_mid_calc();
    test_sweep8(2, 1'b0, 400);
    test_sweep8(3, 1'b1, 400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
